// File: rtl/bk_adder_pkg.sv
// -----------------------------------------------------------------------------
// bk_adder_pkg
// Shared definitions for the Brent-Kung prefix adder slice.
//   BK_WIDTH  : default operand width (power of two, >= 4)
//   BK_LEVELS : number of up-sweep levels, log2(BK_WIDTH)
//   gp_t      : one (generate, propagate) pair as handled by the group operator
// -----------------------------------------------------------------------------
package bk_adder_pkg;

    localparam int BK_WIDTH  = 16;
    localparam int BK_LEVELS = $clog2(BK_WIDTH);

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

endpackage

// File: rtl/bk_prefix_pipe_if.sv
// -----------------------------------------------------------------------------
// bk_prefix_pipe_if
// Upstream (p/g/cin with valid/ready) and downstream (sum/cout with
// valid/ready) channels of the prefix stage.
//   master : the environment side (PG front end + accumulator)
//   slave  : the prefix pipeline itself
// -----------------------------------------------------------------------------
interface bk_prefix_pipe_if #(
    parameter int WIDTH = bk_adder_pkg::BK_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, p, g, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, p, g, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/bk_black_cell.sv
// -----------------------------------------------------------------------------
// bk_black_cell
// Brent-Kung group operator (G,P) o (G',P') = (G | P&G', P&P'), built from
// gate primitives like the PG cell. Used as a gray cell by leaving po open.
//   gh, ph : (G,P) of the more significant group
//   gl, pl : (G,P) of the less significant group
//   go, po : combined group (G,P)
// -----------------------------------------------------------------------------
module bk_black_cell (
    input  wire gh,
    input  wire ph,
    input  wire gl,
    input  wire pl,
    output wire go,
    output wire po
);

    wire ph_gl;

    and u_and_pg (ph_gl, ph, gl);
    or  u_or_g   (go, gh, ph_gl);
    and u_and_p  (po, ph, pl);

endmodule

// File: rtl/bk_prefix_pipe.sv
// -----------------------------------------------------------------------------
// bk_prefix_pipe
// Two-stage Brent-Kung prefix-carry and sum stage.
//   S1: up-sweep of the prefix tree on the incoming p/g, registered.
//   S2: down-sweep, cin fold, sum/cout formation, registered.
// One addition per cycle, two-cycle latency, back-pressure from out_ready.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bk_prefix_pipe_if (in_valid/in_ready/p/g/cin,
//           out_valid/out_ready/sum/cout)
// -----------------------------------------------------------------------------
module bk_prefix_pipe
    import bk_adder_pkg::*;
#(
    parameter int WIDTH = BK_WIDTH   // power of two, >= 4
) (
    input  logic              clk,
    input  logic              rst_n,
    bk_prefix_pipe_if.slave   bus
);

    localparam int LEVELS = $clog2(WIDTH);

    // ---------------------------------------------------------------- control
    logic s1_valid;
    logic s2_adv;

    assign s2_adv       = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_adv;

    // --------------------------------------------------------------- up-sweep
    // Level l combines node i with node i-2^l wherever i+1 is a multiple of
    // 2^(l+1). P is kept everywhere because cin is folded in after the tree.
    for (genvar l = 0; l < LEVELS; l++) begin : g_up
        wire [WIDTH-1:0] src_g, src_p, lvl_g, lvl_p;

        if (l == 0) begin : g_src
            assign src_g = bus.g;
            assign src_p = bus.p;
        end else begin : g_src
            assign src_g = g_up[l-1].lvl_g;
            assign src_p = g_up[l-1].lvl_p;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_node
            if ((i + 1) % (2 ** (l + 1)) == 0) begin : g_cell
                bk_black_cell u_cell (
                    .gh (src_g[i]),
                    .ph (src_p[i]),
                    .gl (src_g[i - 2 ** l]),
                    .pl (src_p[i - 2 ** l]),
                    .go (lvl_g[i]),
                    .po (lvl_p[i])
                );
            end else begin : g_pass
                assign lvl_g[i] = src_g[i];
                assign lvl_p[i] = src_p[i];
            end
        end
    end

    // ------------------------------------------------------------- S1 stage
    gp_t [WIDTH-1:0] s1_gp;
    logic [WIDTH-1:0] s1_p;
    logic             s1_cin;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the S1 data registers are reset as well as the valid bit, so the
    // down-sweep never sees X after reset even while s1_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_gp    <= '0;
            s1_p     <= '0;
            s1_cin   <= 1'b0;
        end else if (bus.in_ready) begin
            // Loads even when in_valid is low; only s1_valid qualifies it.
            s1_valid <= bus.in_valid;
            for (int i = 0; i < WIDTH; i++) begin
                s1_gp[i].g <= g_up[LEVELS-1].lvl_g[i];
                s1_gp[i].p <= g_up[LEVELS-1].lvl_p[i];
            end
            s1_p   <= bus.p;
            s1_cin <= bus.cin;
        end
    end

    logic [WIDTH-1:0] s1_g_vec, s1_p_vec;

    // NOTE: every always_comb output gets a default before any conditional
    // logic, so no path can infer a latch.
    always_comb begin
        s1_g_vec = '0;
        s1_p_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s1_g_vec[i] = s1_gp[i].g;
            s1_p_vec[i] = s1_gp[i].p;
        end
    end

    // ------------------------------------------------------------- down-sweep
    // Level l (from LEVELS-2 down to 0) completes node i = k*2^(l+1) + 2^l - 1,
    // k >= 1, from node i-2^l, which already holds its full prefix.
    for (genvar d = 0; d < LEVELS - 1; d++) begin : g_dn
        localparam int SPAN = 2 ** (LEVELS - 2 - d);
        wire [WIDTH-1:0] src_g, src_p, lvl_g, lvl_p;

        if (d == 0) begin : g_src
            assign src_g = s1_g_vec;
            assign src_p = s1_p_vec;
        end else begin : g_src
            assign src_g = g_dn[d-1].lvl_g;
            assign src_p = g_dn[d-1].lvl_p;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_node
            if (((i + 1) % (2 * SPAN) == SPAN) && (i >= 2 * SPAN)) begin : g_cell
                bk_black_cell u_cell (
                    .gh (src_g[i]),
                    .ph (src_p[i]),
                    .gl (src_g[i - SPAN]),
                    .pl (src_p[i - SPAN]),
                    .go (lvl_g[i]),
                    .po (lvl_p[i])
                );
            end else begin : g_pass
                assign lvl_g[i] = src_g[i];
                assign lvl_p[i] = src_p[i];
            end
        end
    end

    // ---------------------------------------------------- cin fold and sum
    // c[i+1] = G[i:0] | (P[i:0] & cin); c[0] = cin.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_nxt;

    always_comb begin
        carry    = '0;
        carry[0] = s1_cin;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = g_dn[LEVELS-2].lvl_g[i] | (g_dn[LEVELS-2].lvl_p[i] & s1_cin);
        end
        sum_nxt = s1_p ^ carry[WIDTH-1:0];
    end

    // ------------------------------------------------------------- S2 stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.sum       <= '0;
            bus.cout      <= 1'b0;
        end else if (s2_adv) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.sum  <= sum_nxt;
                bus.cout <= carry[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_bk_prefix_pipe.sv
// -----------------------------------------------------------------------------
// tb_bk_prefix_pipe
// Self-checking bench for bk_prefix_pipe (WIDTH=16). Expected results come
// from plain integer addition a+b+cin (or p + 2g + cin) and a queue of
// in-flight operands tagged with their accept edge.
// -----------------------------------------------------------------------------
module tb_bk_prefix_pipe;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bk_prefix_pipe_if #(.WIDTH(W)) bus ();

    bk_prefix_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [W:0] exp_q[$];   // expected {cout,sum} of operands in flight
    int         acc_q[$];   // edge number at which each was accepted

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // One operand into an empty pipeline with the consumer always ready.
    task automatic run_single(input logic [W-1:0] p_v, input logic [W-1:0] g_v,
                              input logic c_v, input logic [W:0] exp, input string tag);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.p         = p_v;
        bus.g         = g_v;
        bus.cin       = c_v;
        #1;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();                               // accept edge
        bus.in_valid = 1'b0;
        bus.p        = '0;
        bus.g        = '0;
        bus.cin      = 1'b0;
        check({tag, "_valid_e1"}, 32'(bus.out_valid), 32'd0);
        tick();
        check({tag, "_valid_e2"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_result"}, 32'({bus.cout, bus.sum}), 32'(exp));
        tick();                               // consumed
        check({tag, "_valid_e3"}, 32'(bus.out_valid), 32'd0);
    endtask

    // Stream n_ops random operands. mode 0: consumer always ready, producer
    // never idle. mode 1: as 0 but consumer stalls 3 cycles from first
    // out_valid. mode 2: random producer gaps and random consumer stalls.
    task automatic stream(input int n_ops, input int mode, input string tag,
                          input int budget, output int n_full);
        int         sent = 0;
        int         got = 0;
        int         cyc = 0;
        int         stall_left = 0;
        bit         seen = 1'b0;
        bit         have_op = 1'b0;
        bit         ov_exp, take, acc;
        logic [W-1:0] a = '0;
        logic [W-1:0] b = '0;
        logic         c = 1'b0;
        n_full = 0;
        exp_q.delete();
        acc_q.delete();
        while (got < n_ops && cyc < budget) begin
            tick();
            cyc++;
            ov_exp = (exp_q.size() > 0) && (acc_q[0] < cyc);
            check({tag, "_out_valid"}, 32'(bus.out_valid), 32'(ov_exp));
            if (ov_exp && bus.out_valid)
                check({tag, "_data"}, 32'({bus.cout, bus.sum}), 32'(exp_q[0]));

            if (mode == 0) begin
                bus.out_ready = 1'b1;
            end else if (mode == 1) begin
                if (bus.out_valid && !seen) begin
                    seen       = 1'b1;
                    stall_left = 3;
                end
                bus.out_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end else begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end

            if (!have_op && sent < n_ops) begin
                a = W'($urandom());
                b = W'($urandom());
                c = 1'($urandom());
                have_op = 1'b1;
            end
            bus.in_valid = have_op && (mode != 2 || $urandom_range(0, 3) != 0);
            if (bus.in_valid) begin
                bus.p   = a ^ b;
                bus.g   = a & b;
                bus.cin = c;
            end else begin
                bus.p   = W'($urandom());
                bus.g   = W'($urandom());
                bus.cin = 1'($urandom());
            end
            #1;
            if (exp_q.size() == 2 && !bus.out_ready) n_full++;
            check({tag, "_in_ready"}, 32'(bus.in_ready),
                  32'(!(exp_q.size() == 2 && !bus.out_ready)));

            take = bus.out_valid && bus.out_ready;
            acc  = bus.in_valid && bus.in_ready;
            if (take && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
                got++;
            end
            if (acc) begin
                exp_q.push_back(ref_add(a, b, c));
                acc_q.push_back(cyc + 1);
                sent++;
                have_op = 1'b0;
            end
        end
        check({tag, "_delivered"}, 32'(got), 32'(n_ops));
        tick();                               // last take lands here
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int n_full;
        logic [W-1:0] ra, rb;

        bus.in_valid  = 1'b0;
        bus.p         = '0;
        bus.g         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        // ------------------------------------------------ reset state
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum",       32'(bus.sum),       32'd0);
        check("rst_cout",      32'(bus.cout),      32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ------------------------------------------------ directed vectors
        run_single(16'h5115, 16'h0220, 1'b0, 17'h05555, "x1234_4321");
        run_single(16'hFFFE, 16'h0001, 1'b0, 17'h10000, "ripple");
        run_single(16'hFFFF, 16'h0000, 1'b1, 17'h10000, "prop_cin1");
        run_single(16'hFFFF, 16'h0000, 1'b0, 17'h0FFFF, "prop_cin0");

        // ------------------------------------------------ stall and streaming
        stream(4, 1, "stall", 200, n_full);
        check("stall_full_seen", 32'(n_full > 0), 32'd1);
        stream(8, 0, "stream", 200, n_full);
        check("stream_no_stall", 32'(n_full), 32'd0);

        // ------------------------------------------------ reset with both stages full
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.p         = 16'h00FF;
        bus.g         = 16'h0F00;
        bus.cin       = 1'b1;
        tick();
        bus.p = 16'h1111;
        bus.g = 16'h2222;
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("full_out_valid", 32'(bus.out_valid), 32'd1);
        check("full_in_ready",  32'(bus.in_ready),  32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_sum",       32'(bus.sum),       32'd0);
        check("midrst_cout",      32'(bus.cout),      32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        bus.out_ready = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_idle", 32'(bus.out_valid), 32'd0);
        end
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        ra = W'($urandom());
        rb = W'($urandom());
        run_single(ra ^ rb, ra & rb, 1'b1, ref_add(ra, rb, 1'b1), "post_rst_op");

        // ------------------------------------------------ random soak
        stream(10000, 2, "rand", 60000, n_full);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bk_prefix_pipe.md
# bk_prefix_pipe

Pipelined Brent-Kung prefix-carry and sum stage that consumes the per-bit propagate/generate vectors produced by the `PG_generate` cell array. It returns the final sum and carry-out of a WIDTH-bit addition. It sits between the PG-generate front end and the FIR accumulator, and registers its result behind a valid/ready handshake so the accumulator can stall it. Throughput is one addition per cycle, latency is 2 cycles.

## Interface
- `WIDTH`, 16: operand width in bits; must be a power of two and ≥ 4.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `in_valid`  input  1  `p`/`g`/`cin` hold a valid operand set.
- `in_ready`  output  1  stage can accept this cycle; combinational.
- `p`  input  WIDTH  per-bit propagate, p[i] = a[i] ^ b[i].
- `g`  input  WIDTH  per-bit generate, g[i] = a[i] & b[i].
- `cin`  input  1  carry into bit 0.
- `out_valid`  output  1  `sum`/`cout` valid; registered.
- `out_ready`  input  1  consumer accepts this cycle.
- `sum`  output  WIDTH  sum[i] = p[i] ^ c[i]; registered.
- `cout`  output  1  carry out of bit WIDTH-1; registered.

## Operation
- Carry definition:
  - c[0] = cin.
  - c[i+1] = G[i:0] | (P[i:0] & cin).
  - Group operator: (G,P)∘(G',P') = (G | P&G', P&P').
- Stage 1 (S1):
  - On accept (`in_valid && in_ready`), the Brent-Kung up-sweep, log2(WIDTH) levels, is computed combinationally from `p`/`g`.
  - S1 registers the partial (G,P) array, the raw `p`, `cin`, and `s1_valid`.
- Stage 2 (S2):
  - The down-sweep, log2(WIDTH)-1 levels, is computed from the S1 registers.
  - cin is folded in, then sum and cout are formed.
  - S2 registers `sum`, `cout` and `out_valid`.
- Handshake and control:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = !s1_valid || s2_adv.
  - Each stage holds its contents when it is not advancing.
  - Data presented while `in_valid`=0 is ignored; S1 registers may still load when not valid.
- Arithmetic: all WIDTH bits are used, no saturation, and carry wraps into `cout` only.
- Control is two valid bits only; there is no FSM beyond the pipeline occupancy states EMPTY, S1, S2, BOTH.

## Timing
- Reset values:
  - `out_valid`=0, `sum`=0, `cout`=0.
  - `s1_valid`=0, S1 data=0.
  - `in_ready` reads 1 once reset is applied.
- Latency: an operand accepted at edge k appears with `out_valid`=1 after edge k+1 and is consumable at edge k+2 when there is no stall.
- Full-throughput streaming holds while `out_ready`=1 continuously.
- Pipeline full (`s1_valid` && `out_valid` && !`out_ready`): `in_ready`=0, and `sum`/`cout` are stable until taken.
- Simultaneous events:
  - Output taken and a new input accepted in the same cycle: both stages shift, with no bubble and no duplicate.
  - Output taken with S1 empty and no input: `out_valid` falls on that edge.
- Reset asserted mid-operation: in-flight data is discarded immediately (asynchronous), and no stale `out_valid` appears after reset release.
- `rst_n` deassertion is synchronised externally; the block assumes release is synchronous to `clk`.

## Structure
- Shared package `bk_adder_pkg`:
  - `BK_WIDTH` default (16).
  - `BK_LEVELS` = $clog2(BK_WIDTH).
  - A struct `gp_t` {g,p} used by the group-operator cell.
- Sub-module `bk_black_cell` (gate-level `and`/`or` primitives, same style as the PG cell):
  - Inputs gh, ph, gl, pl; outputs go, po.
  - Instantiated by generate loops for both sweeps.
- Gray cells (G only) are instances of `bk_black_cell` with `po` left unconnected.

## Test plan
- With WIDTH=16, drive a=0x1234, b=0x4321 (p=0x5115, g=0x0220), cin=0, single shot. Require `sum`=0x5555, `cout`=0, and `out_valid` high exactly 2 edges after accept.
- Drive a=0xFFFF, b=0x0001 (p=0xFFFE, g=0x0001), cin=0. Require `sum`=0x0000, `cout`=1, exercising the full ripple carry through the prefix tree.
- Drive p=0xFFFF, g=0x0000, cin=1. Require `sum`=0x0000, `cout`=1; the same vector with cin=0 must give `sum`=0xFFFF, `cout`=0.
- Stream 4 operands back-to-back, hold `out_ready`=0 for 3 cycles from the first `out_valid`, then release. Require:
  - `in_ready`=0 while both stages are full.
  - 4 results delivered in order, with no loss or duplication, and outputs stable while stalled.
- Assert `rst_n`=0 with both stages full, then release. Require:
  - `out_valid`=0, `sum`=0, `cout`=0 immediately on assertion.
  - `in_ready`=1 after release.
  - No output until a new accept plus 2 edges.
- Run 10k random p/g/cin with a random `out_ready` scoreboard; every `sum`/`cout` must match the {cout,sum} = a+b+cin reference.
